// File: rtl/contrast_lut_mc.sv
// Double-buffered, per-channel contrast LUT on an AXI-Stream pixel path.
// Define CONTRAST_BYPASS_EN to add a per-beat `bypass` input that forwards pixels unmapped.
module contrast_lut_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tuser,
  input  logic                         s_axis_tlast,
  output logic [NUM_CH*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  input  logic                         lut_wr_en,
  input  logic [DATA_WIDTH-1:0]        lut_wr_addr,
  input  logic [DATA_WIDTH-1:0]        lut_wr_data,
  input  logic                         lut_swap_req,
  output logic                         lut_swap_pending,
  output logic                         lut_swap_ack,
  output logic                         lut_wr_err,
`ifdef CONTRAST_BYPASS_EN
  input  logic                         bypass,
`endif
  output logic                         active_bank
);

  localparam int DEPTH    = 1 << DATA_WIDTH;
  localparam int TW       = NUM_CH * DATA_WIDTH;
  localparam int LUT_BITS = DEPTH * DATA_WIDTH;
  localparam int AW       = $clog2(LUT_BITS);

  function automatic logic [LUT_BITS-1:0] identity_lut();
    logic [LUT_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(i);
    end
    return v;
  endfunction

  localparam logic [LUT_BITS-1:0] LUT_IDENTITY = identity_lut();

  logic            en;
  logic            accept;
  logic            swap_now;
  logic            swap_apply;
  logic            wr_ok;
  logic            shadow_bank;
  logic [TW-1:0]   s2_data;
  logic [DATA_WIDTH-1:0] mapped [NUM_CH];

  logic            s1_valid_q, s1_valid_d;
  logic [TW-1:0]   s1_data_q, s1_data_d;
  logic            s1_user_q, s1_user_d;
  logic            s1_last_q, s1_last_d;
  logic            s1_bank_q, s1_bank_d;
  logic            m_valid_q, m_valid_d;
  logic [TW-1:0]   m_data_q, m_data_d;
  logic            m_user_q, m_user_d;
  logic            m_last_q, m_last_d;
  logic            active_bank_q, active_bank_d;
  logic            pending_q, pending_d;
  logic            ack_q, ack_d;
  logic            wr_err_q, wr_err_d;
`ifdef CONTRAST_BYPASS_EN
  logic            s1_bypass_q, s1_bypass_d;
`endif

  // Each channel owns a private copy of both banks so every channel gets its own read port.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LUT_BITS-1:0]   bank_mem [2] = '{default: LUT_IDENTITY};
    logic [AW-1:0]         rd_base;
    logic [AW-1:0]         wr_base;

    assign rd_base   = AW'(s1_data_q[c*DATA_WIDTH +: DATA_WIDTH]) * AW'(DATA_WIDTH);
    assign wr_base   = AW'(lut_wr_addr) * AW'(DATA_WIDTH);
    assign mapped[c] = bank_mem[s1_bank_q][rd_base +: DATA_WIDTH];

    always_ff @(posedge clk) begin
      if (wr_ok) begin
        bank_mem[shadow_bank][wr_base +: DATA_WIDTH] <= lut_wr_data;
      end
    end
  end

  always_comb begin
    s2_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s2_data[c*DATA_WIDTH +: DATA_WIDTH] = mapped[c];
    end
`ifdef CONTRAST_BYPASS_EN
    if (s1_bypass_q) begin
      s2_data = s1_data_q;
    end
`endif
  end

  always_comb begin
    en          = !m_valid_q || m_axis_tready;
    accept      = s_axis_tvalid && en;
    swap_now    = pending_q || lut_swap_req;
    swap_apply  = accept && s_axis_tuser && swap_now;
    // Shadow writes are frozen from the request until the swap lands, so a frame never sees a half-written curve.
    wr_ok       = lut_wr_en && !swap_now;
    shadow_bank = !active_bank_q;

    s1_valid_d    = s1_valid_q;
    s1_data_d     = s1_data_q;
    s1_user_d     = s1_user_q;
    s1_last_d     = s1_last_q;
    s1_bank_d     = s1_bank_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_user_d      = m_user_q;
    m_last_d      = m_last_q;
`ifdef CONTRAST_BYPASS_EN
    s1_bypass_d   = s1_bypass_q;
`endif
    active_bank_d = active_bank_q ^ swap_apply;
    pending_d     = swap_now && !swap_apply;
    ack_d         = swap_apply;
    wr_err_d      = lut_wr_en && swap_now;

    if (en) begin
      s1_valid_d = accept;
      s1_data_d  = s_axis_tdata;
      s1_user_d  = s_axis_tuser;
      s1_last_d  = s_axis_tlast;
      s1_bank_d  = active_bank_d;
`ifdef CONTRAST_BYPASS_EN
      s1_bypass_d = bypass;
`endif
      m_valid_d  = s1_valid_q;
      m_data_d   = s2_data;
      m_user_d   = s1_user_q;
      m_last_d   = s1_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_user_q     <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_bank_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_user_q      <= 1'b0;
      m_last_q      <= 1'b0;
      active_bank_q <= 1'b0;
      pending_q     <= 1'b0;
      ack_q         <= 1'b0;
      wr_err_q      <= 1'b0;
`ifdef CONTRAST_BYPASS_EN
      s1_bypass_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_user_q     <= s1_user_d;
      s1_last_q     <= s1_last_d;
      s1_bank_q     <= s1_bank_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_user_q      <= m_user_d;
      m_last_q      <= m_last_d;
      active_bank_q <= active_bank_d;
      pending_q     <= pending_d;
      ack_q         <= ack_d;
      wr_err_q      <= wr_err_d;
`ifdef CONTRAST_BYPASS_EN
      s1_bypass_q   <= s1_bypass_d;
`endif
    end
  end

  assign s_axis_tready    = en;
  assign m_axis_tvalid    = m_valid_q;
  assign m_axis_tdata     = m_data_q;
  assign m_axis_tuser     = m_user_q;
  assign m_axis_tlast     = m_last_q;
  assign active_bank      = active_bank_q;
  assign lut_swap_pending = pending_q;
  assign lut_swap_ack     = ack_q;
  assign lut_wr_err       = wr_err_q;

endmodule

// File: doc/contrast_lut_mc.md
# contrast_lut_mc

Multi-channel, runtime-programmable contrast mapping stage for the AXI-Stream video pipeline. Each pixel component is remapped through a 2**DATA_WIDTH-entry lookup table. The table is double-buffered: software writes the shadow bank while the active bank serves traffic, and a requested bank swap takes effect only on a start-of-frame beat, so no frame is ever mapped by two different curves. The block sits between the sensor/AXIS input and downstream processing, replacing the fixed compile-time contrast curve with full backpressure support.

## Interface
- DATA_WIDTH, 8, bits per channel; LUT depth is 2**DATA_WIDTH.
- NUM_CH, 1, channels per beat (1..4); channel c occupies tdata[c*DATA_WIDTH +: DATA_WIDTH].
- clk  in  1  single clock for all logic.
- rst  in  1  reset; synchronous and active-high.
- s_axis  AxiStreamIf.Slave  tdata NUM_CH*DATA_WIDTH, tuser 1 (start of frame), tlast 1 (end of line).
- m_axis  AxiStreamIf.Master  same widths as s_axis.
- lut_wr_en  in  1  write strobe for the shadow bank.
- lut_wr_addr  in  DATA_WIDTH  LUT entry index.
- lut_wr_data  in  DATA_WIDTH  LUT entry value.
- lut_swap_req  in  1  single-cycle pulse; requests shadow/active exchange at the next SOF.
- lut_swap_pending  out  1  a swap is requested but not yet applied.
- lut_swap_ack  out  1  one-cycle pulse in the cycle the swap is applied.
- lut_wr_err  out  1  one-cycle pulse when a write is dropped.
- active_bank  out  1  bank currently mapping pixels.

## Operation
- Two banks, each 2**DATA_WIDTH x DATA_WIDTH. Both are initialised to identity (entry i = i) at configuration time; contents are not changed by rst.
- Writes always target bank !active_bank. A write is dropped, and lut_wr_err pulses, while lut_swap_pending=1 or in the cycle lut_swap_req=1.
- lut_swap_req sets pending. A request that arrives while pending is already set has no further effect.
- The swap is applied on acceptance of an s_axis beat with tuser=1 while pending=1: that beat and all later beats use the new bank. active_bank toggles, pending clears and lut_swap_ack pulses in that cycle.
- All NUM_CH channels of a beat index the same active bank in parallel. Each channel uses an independent read port (replicated storage is allowed).
- tuser and tlast travel with their beat unchanged. Every accepted beat, including tlast beats, produces exactly one output beat. No beat is dropped or duplicated.

## Timing
- Two-stage pipeline: S1 registers pixel, sideband and bank select; S2 registers the LUT outputs. The pipeline advances with en = !m_axis.tvalid || m_axis.tready.
- s_axis.tready = en, which is combinational from m_axis.tready.
- Latency is 2 cycles from s_axis handshake to m_axis.tvalid when m_axis.tready is held at 1. Throughput is 1 beat/cycle.
- With m_axis.tready=0, m_axis.tdata, tuser and tlast are held stable and tvalid does not drop.
- Reset values: m_axis.tvalid=0, tdata=0, tuser=0, tlast=0; S1 valid=0; active_bank=0; lut_swap_pending=0; lut_swap_ack=0; lut_wr_err=0.
- Reset mid-frame discards in-flight beats and any pending swap. LUT contents are retained.
- If lut_swap_req and an accepted SOF beat occur in the same cycle, the swap is applied to that beat.
- A write to the shadow bank is visible after the next swap; the earliest such swap is the SOF beat accepted 1 cycle after the write.

## Configuration
- CONTRAST_BYPASS_EN defined: adds input port bypass (1 bit). While bypass=1, the S2 output equals the input tdata delayed. Latency, handshake and swap logic are unchanged. bypass is sampled per beat at S1.
- CONTRAST_BYPASS_EN undefined: the bypass port and its mux do not exist, and every beat is mapped.

## Test plan
- Reset, identity LUT, DATA_WIDTH=8, NUM_CH=3, tready=1, send beats 0x102030, 0xFFFEFD -> outputs are the same values 2 cycles after each handshake; tuser and tlast are preserved.
- Write shadow entry i = 255-i for all i, pulse lut_swap_req mid-frame, continue the frame -> output is still identity; at the next tuser beat, lut_swap_ack=1 and active_bank=1; pixel 0x10 maps to 0xEF.
- Random m_axis.tready (50%) over 640x4 beats with tlast every 640 beats -> output sequence equals the mapped input; no loss or duplication; data is stable while stalled.
- Write while lut_swap_pending=1 -> lut_wr_err pulses and the table entry is unchanged after the swap.
- Assert rst with 2 beats in flight and a swap pending -> next cycle m_axis.tvalid=0, pending=0, active_bank=0, and the LUT still holds the written curve.
- Compile with CONTRAST_BYPASS_EN, inverted LUT active, bypass=1 -> pixel 0x10 outputs 0x10; with bypass=0 it outputs 0xEF.
